wasm_operand_stack: RTL and testbench

Parametrised operand stack for the wasm CPU core. It replaces the fixed single-purpose result stack. Adds width/depth parameters, multi-entry drop, replace-top, indexed peek, and a sticky 3-bit trap code matching the CPU trap bus. Sits between the decode/execute stage and the CPU result port; the CPU `result`/`result_empty` outputs are driven from `top`/`empty`.

---
 rtl/wasm_stack_defs.sv | 33 +++
 rtl/wasm_operand_stack_ram.sv | 44 ++++
 rtl/wasm_operand_stack.sv | 204 ++++++++++++++++++++
 tb/tb_wasm_operand_stack.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_stack_defs.sv
`default_nettype none
// ============================================================================
// Module      : wasm_stack_defs (package)
// Description : Opcode and trap encodings for the wasm operand stack. The trap
//               codes are shared with the CPU trap bus, so their values must
//               not be renumbered.
// Revision    : 1.0 - initial release
// ============================================================================
package wasm_stack_defs;

    localparam int c_OP_W   = 3;
    localparam int c_TRAP_W = 3;

    typedef enum logic [c_OP_W-1:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_DROP    = 3'd3,
        OP_DROPN   = 3'd4,
        OP_REPLACE = 3'd5,
        OP_PEEK    = 3'd6,
        OP_RSVD    = 3'd7
    } op_e;

    typedef enum logic [c_TRAP_W-1:0] {
        TRAP_NONE      = 3'd0,
        TRAP_UNDERFLOW = 3'd1,
        TRAP_OVERFLOW  = 3'd2,
        TRAP_BAD_OP    = 3'd3
    } trap_e;

endpackage : wasm_stack_defs
`default_nettype wire

// File: rtl/wasm_operand_stack_ram.sv
`default_nettype none
// ============================================================================
// Module      : stack_ram
// Description : DEPTH x WIDTH storage for the operand stack. One synchronous
//               write port and two asynchronous read ports (top refill and
//               indexed peek). No reset: contents are don't-care until written.
// Ports       : clk        - clock
//               i_we       - write enable
//               i_waddr    - write address
//               i_wdata    - write data
//               i_raddr_a  - read address, port A (top refill)
//               o_rdata_a  - read data, port A
//               i_raddr_b  - read address, port B (peek)
//               o_rdata_b  - read data, port B
// Revision    : 1.0 - initial release
// ============================================================================
module stack_ram #(
    parameter  int WIDTH  = 64,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [WIDTH-1:0]  o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [WIDTH-1:0]  o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule : stack_ram
`default_nettype wire

// File: rtl/wasm_operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : wasm_operand_stack
// Description : Parametrised operand stack for the wasm CPU core. Supports
//               push, pop, drop, multi-entry drop, replace-top and indexed
//               peek, one op per cycle. A cached top register is refilled
//               from the array in the same cycle, so `top` never bubbles.
//               Any fault latches a sticky trap code that freezes the stack
//               until reset.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous, active-low
//               op         - operation code (see wasm_stack_defs)
//               op_valid   - qualifies op
//               din        - data for PUSH / REPLACE
//               amount     - DROPN count, or PEEK depth index (0 = top)
//               top        - registered top-of-stack, 0 when empty
//               empty/full - count == 0 / count == DEPTH
//               count      - number of valid entries
//               pop_data   - value removed by the last POP
//               pop_valid  - one-cycle pulse after an accepted POP
//               peek_data  - entry at depth index amount
//               peek_valid - one-cycle pulse after an accepted PEEK
//               trap       - sticky trap code, first fault wins
// Revision    : 1.0 - initial release
// ============================================================================
module wasm_operand_stack
    import wasm_stack_defs::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [CW-1:0]    amount,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
    output logic [2:0]       trap
);

    localparam int            c_AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] c_ONE   = CW'(1);
    localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
    localparam logic [c_AW-1:0] c_A_ONE = c_AW'(1);
    localparam logic [c_AW-1:0] c_A_TWO = c_AW'(2);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_top;
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;
    logic [WIDTH-1:0] r_peek_data;
    logic             r_peek_valid;
    logic [2:0]       r_trap;

    logic             w_empty;
    logic             w_full;
    logic             w_accept;
    logic             w_we;
    logic [c_AW-1:0]  w_cnt_a;
    logic [c_AW-1:0]  w_amt_a;
    logic [c_AW-1:0]  w_waddr;
    logic [c_AW-1:0]  w_refill_addr;
    logic [c_AW-1:0]  w_peek_addr;
    logic [WIDTH-1:0] w_refill_data;
    logic [WIDTH-1:0] w_peek_data;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_DEPTH);
    // A latched trap freezes the stack: nothing is accepted until reset.
    assign w_accept = op_valid && (r_trap == TRAP_NONE);

    // Array addresses are computed modulo the array size. Whenever an address
    // can wrap (count reaching zero), the result is discarded, so the wrap is
    // harmless and avoids carrying the extra count bit into the address path.
    assign w_cnt_a = r_count[c_AW-1:0];
    assign w_amt_a = amount[c_AW-1:0];

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_cnt_a;
        if (w_accept) begin
            if (op == OP_PUSH && !w_full) begin
                w_we = 1'b1;
            end else if (op == OP_REPLACE && !w_empty) begin
                w_we    = 1'b1;
                w_waddr = w_cnt_a - c_A_ONE;
            end
        end
    end

    // Refill source: the entry that becomes the new top after a removal.
    always_comb begin
        w_refill_addr = w_cnt_a - c_A_TWO;
        if (op == OP_DROPN) begin
            w_refill_addr = w_cnt_a - w_amt_a - c_A_ONE;
        end
    end

    assign w_peek_addr = w_cnt_a - c_A_ONE - w_amt_a;

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (din),
        .i_raddr_a (w_refill_addr),
        .o_rdata_a (w_refill_data),
        .i_raddr_b (w_peek_addr),
        .o_rdata_b (w_peek_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count      <= '0;
            r_top        <= '0;
            r_pop_data   <= '0;
            r_pop_valid  <= 1'b0;
            r_peek_data  <= '0;
            r_peek_valid <= 1'b0;
            r_trap       <= TRAP_NONE;
        end else begin
            r_pop_valid  <= 1'b0;
            r_peek_valid <= 1'b0;
            if (w_accept) begin
                case (op)
                    OP_PUSH: begin
                        if (w_full) begin
                            r_trap <= TRAP_OVERFLOW;
                        end else begin
                            r_count <= r_count + c_ONE;
                            r_top   <= din;
                        end
                    end
                    OP_POP, OP_DROP: begin
                        if (w_empty) begin
                            r_trap <= TRAP_UNDERFLOW;
                        end else begin
                            r_count <= r_count - c_ONE;
                            r_top   <= (r_count == c_ONE) ? '0 : w_refill_data;
                            if (op == OP_POP) begin
                                r_pop_data  <= r_top;
                                r_pop_valid <= 1'b1;
                            end
                        end
                    end
                    OP_DROPN: begin
                        if (amount != '0) begin
                            if (amount > r_count) begin
                                r_trap <= TRAP_UNDERFLOW;
                            end else begin
                                r_count <= r_count - amount;
                                r_top   <= (amount == r_count) ? '0 : w_refill_data;
                            end
                        end
                    end
                    OP_REPLACE: begin
                        if (w_empty) begin
                            r_trap <= TRAP_UNDERFLOW;
                        end else begin
                            r_top <= din;
                        end
                    end
                    OP_PEEK: begin
                        if (amount >= r_count) begin
                            r_trap <= TRAP_UNDERFLOW;
                        end else begin
                            r_peek_data  <= w_peek_data;
                            r_peek_valid <= 1'b1;
                        end
                    end
                    OP_RSVD: begin
                        r_trap <= TRAP_BAD_OP;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign top        = r_top;
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign pop_data   = r_pop_data;
    assign pop_valid  = r_pop_valid;
    assign peek_data  = r_peek_data;
    assign peek_valid = r_peek_valid;
    assign trap       = r_trap;

endmodule : wasm_operand_stack
`default_nettype wire

// File: tb/tb_wasm_operand_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_wasm_operand_stack
// Description : Scoreboard bench for wasm_operand_stack. The driver applies
//               one op per cycle, steps a queue-based reference model and
//               queues the expected post-edge state; a monitor on the falling
//               edge pops each expectation and compares every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wasm_operand_stack;

    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] c_NOP = 3'd0, c_PUSH = 3'd1, c_POP = 3'd2, c_DROP = 3'd3;
    localparam logic [2:0] c_DROPN = 3'd4, c_REPL = 3'd5, c_PEEK = 3'd6, c_BAD = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       op;
    logic             op_valid;
    logic [WIDTH-1:0] din;
    logic [CW-1:0]    amount;
    logic [WIDTH-1:0] top;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [WIDTH-1:0] peek_data;
    logic             peek_valid;
    logic [2:0]       trap;

    always #5 clk = ~clk;

    wasm_operand_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .op_valid   (op_valid),
        .din        (din),
        .amount     (amount),
        .top        (top),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .peek_data  (peek_data),
        .peek_valid (peek_valid),
        .trap       (trap)
    );

    typedef struct {
        int               cnt;
        logic [WIDTH-1:0] top;
        logic [2:0]       trap;
        logic             pv;
        logic [WIDTH-1:0] pd;
        logic             kv;
        logic [WIDTH-1:0] kd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: the stack is just a queue, back = top of stack.
    logic [WIDTH-1:0] m_stk[$];
    int               m_trap = 0;
    logic [WIDTH-1:0] m_pd = '0;
    logic [WIDTH-1:0] m_kd = '0;
    logic             m_pv = 1'b0;
    logic             m_kv = 1'b0;

    task automatic model_step(input logic rst_n, input logic valid,
                              input logic [2:0] o, input logic [WIDTH-1:0] d,
                              input int a);
        logic [WIDTH-1:0] v;
        if (!rst_n) begin
            m_stk.delete();
            m_trap = 0;
            m_pd = '0;
            m_kd = '0;
            m_pv = 1'b0;
            m_kv = 1'b0;
            return;
        end
        m_pv = 1'b0;
        m_kv = 1'b0;
        if (!valid || m_trap != 0) return;
        case (o)
            c_PUSH: if (m_stk.size() == DEPTH) m_trap = 2; else m_stk.push_back(d);
            c_POP, c_DROP: begin
                if (m_stk.size() == 0) m_trap = 1;
                else begin
                    v = m_stk.pop_back();
                    if (o == c_POP) begin
                        m_pd = v;
                        m_pv = 1'b1;
                    end
                end
            end
            c_DROPN: begin
                if (a != 0) begin
                    if (a > m_stk.size()) m_trap = 1;
                    else for (int k = 0; k < a; k++) v = m_stk.pop_back();
                end
            end
            c_REPL: if (m_stk.size() == 0) m_trap = 1; else m_stk[m_stk.size()-1] = d;
            c_PEEK: begin
                if (a >= m_stk.size()) m_trap = 1;
                else begin
                    m_kd = m_stk[m_stk.size()-1-a];
                    m_kv = 1'b1;
                end
            end
            c_BAD: m_trap = 3;
            default: begin
            end
        endcase
    endtask

    task automatic do_op(input logic rst_n, input logic valid, input logic [2:0] o,
                         input logic [WIDTH-1:0] d, input int a);
        exp_t e;
        reset    = rst_n;
        op_valid = valid;
        op       = o;
        din      = d;
        amount   = CW'(a);
        model_step(rst_n, valid, o, d, a);
        e.cnt  = m_stk.size();
        e.top  = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
        e.trap = 3'(m_trap);
        e.pv   = m_pv;
        e.pd   = m_pd;
        e.kv   = m_kv;
        e.kd   = m_kd;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("count",      64'(count),      64'(e.cnt));
            check("top",        64'(top),        64'(e.top));
            check("empty",      64'(empty),      64'(e.cnt == 0));
            check("full",       64'(full),       64'(e.cnt == DEPTH));
            check("trap",       64'(trap),       64'(e.trap));
            check("pop_valid",  64'(pop_valid),  64'(e.pv));
            check("pop_data",   64'(pop_data),   64'(e.pd));
            check("peek_valid", 64'(peek_valid), 64'(e.kv));
            check("peek_data",  64'(peek_data),  64'(e.kd));
        end
    end

    initial begin
        int r;
        // Reset held for two cycles, then basic push/pop.
        do_op(1'b0, 1'b0, c_NOP, '0, 0);
        do_op(1'b0, 1'b0, c_NOP, '0, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h11, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h22, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h33, 0);
        do_op(1'b1, 1'b1, c_POP,  '0, 0);
        do_op(1'b1, 1'b0, c_NOP,  '0, 0);

        // Fill to full, overflow, then a POP that must be ignored.
        do_op(1'b0, 1'b0, c_NOP, '0, 0);
        for (int i = 1; i <= DEPTH; i++) do_op(1'b1, 1'b1, c_PUSH, WIDTH'(i), 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'hFF, 0);
        do_op(1'b1, 1'b1, c_POP,  '0, 0);

        // Multi-entry drops down to empty, then underflow.
        do_op(1'b0, 1'b0, c_NOP, '0, 0);
        for (int i = 10; i <= 14; i++) do_op(1'b1, 1'b1, c_PUSH, WIDTH'(i), 0);
        do_op(1'b1, 1'b1, c_DROPN, '0, 0);
        do_op(1'b1, 1'b1, c_DROPN, '0, 3);
        do_op(1'b1, 1'b1, c_DROPN, '0, 2);
        do_op(1'b1, 1'b1, c_DROPN, '0, 1);

        // Indexed peek, then peek past the bottom.
        do_op(1'b0, 1'b0, c_NOP, '0, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h7, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h8, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h9, 0);
        do_op(1'b1, 1'b1, c_PEEK, '0, 2);
        do_op(1'b1, 1'b1, c_PEEK, '0, 0);
        do_op(1'b1, 1'b1, c_PEEK, '0, 3);

        // Replace, drop to empty, reserved op.
        do_op(1'b0, 1'b0, c_NOP, '0, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h5, 0);
        do_op(1'b1, 1'b1, c_REPL, 64'h1234, 0);
        do_op(1'b1, 1'b1, c_DROP, '0, 0);
        do_op(1'b1, 1'b1, c_BAD,  '0, 0);

        // Reset overrides a concurrent push and clears the trap.
        do_op(1'b0, 1'b1, c_PUSH, 64'h55, 0);
        do_op(1'b1, 1'b1, c_PUSH, 64'h66, 0);

        // Randomised phase.
        for (int i = 0; i < 1500; i++) begin
            logic [WIDTH-1:0] d;
            logic [2:0]       o;
            logic             v;
            d = {$urandom, $urandom};
            r = $urandom_range(0, 99);
            v = 1'b1;
            if (r < 30)      o = c_PUSH;
            else if (r < 42) o = c_POP;
            else if (r < 50) o = c_DROP;
            else if (r < 60) o = c_DROPN;
            else if (r < 70) o = c_REPL;
            else if (r < 85) o = c_PEEK;
            else if (r < 92) o = c_NOP;
            else if (r < 93) o = c_BAD;
            else begin
                o = 3'($urandom_range(0, 7));
                v = 1'b0;
            end
            if ((m_trap != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
                do_op(1'b0, v, o, d, 0);
            else
                do_op(1'b1, v, o, d, $urandom_range(0, DEPTH + 1));
        end

        do_op(1'b1, 1'b0, c_NOP, '0, 0);
        do_op(1'b1, 1'b0, c_NOP, '0, 0);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wasm_operand_stack
`default_nettype wire
